// File: rtl/encode_tx.sv
// Response framer: pops BYTE_NUM bytes from the SDRAM read FIFO and sends
// HEAD, the data bytes and an XOR checksum to uart_tx one byte at a time.
module encode_tx #(
   parameter int unsigned BYTE_NUM = 4,
   parameter logic [7:0]  HEAD     = 8'hA5,
   parameter int unsigned TIMEOUT  = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rd_done,
   input  logic       i_rfifo_empty,
   input  logic [7:0] i_rfifo_rd_data,
   output logic       o_rfifo_rd_en,
   input  logic       i_flag_tx_end,
   output logic       o_tx_trig,
   output logic [7:0] o_tx_data,
   output logic       o_busy,
   output logic       o_tx_done,
   output logic       o_err
);

   typedef enum logic [3:0] {
      StIdle, StHead, StWaitH, StFetch, StLatch, StSend, StWaitD, StChk, StWaitC
   } state_e;

   localparam logic [7:0]  LastByte = 8'(BYTE_NUM - 1);
   localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);

   state_e      r_state, w_state_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [7:0]  r_chk, w_chk_nxt;
   logic [15:0] r_tmo, w_tmo_nxt;
   logic [7:0]  r_tx_data, w_tx_data_nxt;
   logic        r_tx_trig, w_tx_trig_nxt;
   logic        r_rd_en, w_rd_en_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_tx_done, w_tx_done_nxt;
   logic        r_err, w_err_nxt;
   logic        w_end;

   // An end pulse coinciding with our own trigger belongs to the previous byte.
   assign w_end = i_flag_tx_end & ~r_tx_trig;

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_chk_nxt     = r_chk;
      w_tmo_nxt     = r_tmo;
      w_tx_data_nxt = r_tx_data;
      w_tx_trig_nxt = 1'b0;
      w_rd_en_nxt   = 1'b0;
      w_tx_done_nxt = 1'b0;
      w_err_nxt     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_rd_done) begin
               w_state_nxt   = StHead;
               w_tx_trig_nxt = 1'b1;
               w_tx_data_nxt = HEAD;
               w_cnt_nxt     = 8'd0;
               w_chk_nxt     = 8'd0;
               w_tmo_nxt     = 16'd0;
            end
         end
         StHead:  w_state_nxt = StWaitH;
         StWaitH: if (w_end) w_state_nxt = StFetch;
         StFetch: begin
            if (!i_rfifo_empty) begin
               w_rd_en_nxt = 1'b1;
               w_tmo_nxt   = 16'd0;
               w_state_nxt = StLatch;
            end else if (r_tmo == TmoLast) begin
               w_err_nxt   = 1'b1;
               w_tmo_nxt   = 16'd0;
               w_state_nxt = StIdle;
            end else begin
               w_tmo_nxt = r_tmo + 16'd1;
            end
         end
         // rd_en is visible during StLatch; FIFO data arrives in StSend.
         StLatch: w_state_nxt = StSend;
         StSend: begin
            w_tx_data_nxt = i_rfifo_rd_data;
            w_chk_nxt     = r_chk ^ i_rfifo_rd_data;
            w_tx_trig_nxt = 1'b1;
            w_state_nxt   = StWaitD;
         end
         StWaitD: begin
            if (w_end) begin
               if (r_cnt == LastByte) begin
                  w_tx_data_nxt = r_chk;
                  w_tx_trig_nxt = 1'b1;
                  w_state_nxt   = StChk;
               end else begin
                  w_cnt_nxt   = r_cnt + 8'd1;
                  w_state_nxt = StFetch;
               end
            end
         end
         StChk: w_state_nxt = StWaitC;
         StWaitC: begin
            if (w_end) begin
               w_tx_done_nxt = 1'b1;
               w_state_nxt   = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
      w_busy_nxt = (w_state_nxt != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_cnt     <= 8'd0;
         r_chk     <= 8'd0;
         r_tmo     <= 16'd0;
         r_tx_data <= 8'h00;
         r_tx_trig <= 1'b0;
         r_rd_en   <= 1'b0;
         r_busy    <= 1'b0;
         r_tx_done <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_chk     <= w_chk_nxt;
         r_tmo     <= w_tmo_nxt;
         r_tx_data <= w_tx_data_nxt;
         r_tx_trig <= w_tx_trig_nxt;
         r_rd_en   <= w_rd_en_nxt;
         r_busy    <= w_busy_nxt;
         r_tx_done <= w_tx_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign o_rfifo_rd_en = r_rd_en;
   assign o_tx_trig     = r_tx_trig;
   assign o_tx_data     = r_tx_data;
   assign o_busy        = r_busy;
   assign o_tx_done     = r_tx_done;
   assign o_err         = r_err;

endmodule

// File: tb/tb_encode_tx.sv
// Directed bench for encode_tx: FIFO and uart_tx models shared by a default
// instance and a short-timeout instance, selected by sel.
module tb_encode_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic       rd_done0 = 1'b0, rd_done1 = 1'b0;
   logic       fifo_empty;
   logic [7:0] rd_data = 8'h00;
   logic       flag = 1'b0;

   logic       rd_en0, trig0, busy0, done0, err0;
   logic       rd_en1, trig1, busy1, done1, err1;
   logic [7:0] data0, data1;
   logic       m_rd_en, m_trig, m_busy, m_done, m_err;
   logic [7:0] m_data;

   always #5 clk = ~clk;

   encode_tx u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_rd_done(rd_done0), .i_rfifo_empty(fifo_empty),
      .i_rfifo_rd_data(rd_data), .o_rfifo_rd_en(rd_en0), .i_flag_tx_end(flag & ~sel),
      .o_tx_trig(trig0), .o_tx_data(data0), .o_busy(busy0), .o_tx_done(done0), .o_err(err0)
   );

   encode_tx #(.TIMEOUT(15)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_rd_done(rd_done1), .i_rfifo_empty(fifo_empty),
      .i_rfifo_rd_data(rd_data), .o_rfifo_rd_en(rd_en1), .i_flag_tx_end(flag & sel),
      .o_tx_trig(trig1), .o_tx_data(data1), .o_busy(busy1), .o_tx_done(done1), .o_err(err1)
   );

   assign m_rd_en = sel ? rd_en1 : rd_en0;
   assign m_trig  = sel ? trig1  : trig0;
   assign m_data  = sel ? data1  : data0;
   assign m_busy  = sel ? busy1  : busy0;
   assign m_done  = sel ? done1  : done0;
   assign m_err   = sel ? err1   : err0;

   logic [7:0] mem [0:255];
   int         wr_ptr = 0, rd_ptr = 0;
   logic       pend = 1'b0;
   logic [7:0] pend_val = 8'h00;
   int         cd = 0, cyc = 0, t_trig = 0, t_err = 0;
   int         rd_cnt = 0, done_cnt = 0, err_cnt = 0, underflow = 0;
   logic       busy_at_err = 1'b1;
   logic [7:0] tlog [$];

   assign fifo_empty = (rd_ptr == wr_ptr);

   // FIFO data shows up only in the cycle after the pop; uart end 10 cycles after trig.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) cd <= 0;
      else if (m_trig) cd <= 10;
      else if (cd > 0) cd <= cd - 1;
      flag <= rst_n && !m_trig && (cd == 1);
      if (m_trig) begin
         tlog.push_back(m_data);
         t_trig <= cyc;
      end
      if (m_rd_en) begin
         rd_cnt  <= rd_cnt + 1;
         pend    <= 1'b1;
         rd_data <= 8'hEE;
         if (rd_ptr == wr_ptr) underflow <= underflow + 1;
         else begin
            pend_val <= mem[rd_ptr[7:0]];
            rd_ptr   <= rd_ptr + 1;
         end
      end else if (pend) begin
         rd_data <= pend_val;
         pend    <= 1'b0;
      end
      if (m_done) done_cnt <= done_cnt + 1;
      if (m_err) begin
         err_cnt     <= err_cnt + 1;
         t_err       <= cyc;
         busy_at_err <= m_busy;
      end
   end

   int checks = 0, failures = 0;
   int b_done, b_err, b_rd, b_log;
   logic [47:0] pk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr++;
   endtask

   task automatic base();
      b_done = done_cnt;
      b_err  = err_cnt;
      b_rd   = rd_cnt;
      b_log  = tlog.size();
   endtask

   task automatic pulse(input logic which);
      if (which) rd_done1 = 1'b1;
      else rd_done0 = 1'b1;
      step(1);
      rd_done0 = 1'b0;
      rd_done1 = 1'b0;
   endtask

   task automatic wait_ends(input int n, input int budget);
      int k = 0;
      while ((done_cnt + err_cnt) < (b_done + b_err + n) && k < budget) begin
         step(1);
         k++;
      end
   endtask

   function automatic logic [47:0] pack6(input int s);
      logic [47:0] v = 48'h0;
      for (int i = 0; i < 6; i++) begin
         v = v << 8;
         if (s + i < tlog.size()) v[7:0] = tlog[s + i];
      end
      return v;
   endfunction

   initial begin
      step(2);
      check("rst_flags", 64'({trig0, rd_en0, busy0, done0, err0}), 64'd0);
      check("rst_data", 64'(data0), 64'h00);
      rst_n = 1'b1;
      step(2);

      // Basic frame
      base();
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      pulse(1'b0);
      check("t1_hdr_trig_busy", 64'({m_trig, m_busy}), 64'b11);
      check("t1_hdr_data", 64'(m_data), 64'hA5);
      wait_ends(1, 300);
      check("t1_done", 64'(done_cnt - b_done), 64'd1);
      check("t1_bytes", 64'(tlog.size() - b_log), 64'd6);
      check("t1_seq", 64'(pack6(b_log)), 64'hA51122334444);
      check("t1_pops", 64'(rd_cnt - b_rd), 64'd4);
      check("t1_busy_after", 64'(m_busy), 64'd0);

      // Stall at second fetch
      base();
      push(8'h11);
      pulse(1'b0);
      step(40);
      check("t2_stall_bytes", 64'(tlog.size() - b_log), 64'd2);
      step(50);
      check("t2_stall_bytes_late", 64'(tlog.size() - b_log), 64'd2);
      check("t2_stall_pops", 64'(rd_cnt - b_rd), 64'd1);
      check("t2_stall_busy", 64'(m_busy), 64'd1);
      push(8'h22); push(8'h33); push(8'h44);
      wait_ends(1, 300);
      check("t2_done", 64'(done_cnt - b_done), 64'd1);
      check("t2_seq", 64'(pack6(b_log)), 64'hA51122334444);
      check("t2_pops", 64'(rd_cnt - b_rd), 64'd4);
      check("t2_underflow", 64'(underflow), 64'd0);

      // Timeout on the TIMEOUT=15 instance
      sel = 1'b1;
      step(2);
      base();
      pulse(1'b1);
      wait_ends(1, 200);
      check("t3a_err", 64'(err_cnt - b_err), 64'd1);
      check("t3a_err_time", 64'(t_err - t_trig), 64'd26);
      check("t3a_busy_at_err", 64'(busy_at_err), 64'd0);
      check("t3a_bytes", 64'(tlog.size() - b_log), 64'd1);
      step(5);
      base();
      push(8'h55);
      pulse(1'b1);
      wait_ends(1, 200);
      pk = pack6(b_log);
      check("t3b_err", 64'(err_cnt - b_err), 64'd1);
      check("t3b_seq", 64'(pk), 64'hA55500000000);
      step(5);
      base();
      push(8'h01); push(8'h02); push(8'h04); push(8'h08);
      pulse(1'b1);
      wait_ends(1, 300);
      check("t3c_done", 64'(done_cnt - b_done), 64'd1);
      check("t3c_seq", 64'(pack6(b_log)), 64'hA5010204080F);
      sel = 1'b0;
      step(2);

      // rd_done during WAIT_D is ignored
      base();
      push(8'hAA); push(8'h55); push(8'h0F); push(8'hF0);
      pulse(1'b0);
      for (int k = 0; k < 100 && (tlog.size() - b_log) < 2; k++) step(1);
      pulse(1'b0);
      wait_ends(1, 300);
      step(40);
      check("t4_done", 64'(done_cnt - b_done), 64'd1);
      check("t4_bytes", 64'(tlog.size() - b_log), 64'd6);
      check("t4_seq", 64'(pack6(b_log)), 64'hA5AA550FF000);
      check("t4_pops", 64'(rd_cnt - b_rd), 64'd4);

      // Reset in the middle of byte 2
      base();
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      pulse(1'b0);
      for (int k = 0; k < 100 && (tlog.size() - b_log) < 3; k++) step(1);
      rst_n = 1'b0;
      step(1);
      check("t5_rst_flags", 64'({m_trig, m_rd_en, m_busy, m_done, m_err}), 64'd0);
      check("t5_rst_data", 64'(m_data), 64'h00);
      step(2);
      wr_ptr = rd_ptr;
      rst_n = 1'b1;
      step(2);
      base();
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      pulse(1'b0);
      wait_ends(1, 300);
      check("t5_done", 64'(done_cnt - b_done), 64'd1);
      check("t5_seq", 64'(pack6(b_log)), 64'hA50102030404);

      // Back-to-back frames, rd_done coincident with tx_done
      base();
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      push(8'h10); push(8'h20); push(8'h30); push(8'h40);
      pulse(1'b0);
      for (int k = 0; k < 300 && !m_done; k++) step(1);
      check("t6_first_done", 64'(m_done), 64'd1);
      pulse(1'b0);
      check("t6_hdr2", 64'({m_trig, m_data}), 64'h1A5);
      wait_ends(2, 300);
      check("t6_done", 64'(done_cnt - b_done), 64'd2);
      check("t6_bytes", 64'(tlog.size() - b_log), 64'd12);
      check("t6_seq1", 64'(pack6(b_log)), 64'hA50102030404);
      check("t6_seq2", 64'(pack6(b_log + 6)), 64'hA51020304040);
      check("t6_pops", 64'(rd_cnt - b_rd), 64'd8);
      check("t6_underflow", 64'(underflow), 64'd0);
      check("t6_no_err", 64'(err_cnt - b_err), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/encode_tx.md
Name: encode_tx

Overview:
- Response-path framer for the UART-to-SDRAM bridge.
- After an SDRAM read burst has filled the read FIFO, it pops BYTE_NUM bytes and streams them to the UART transmitter one byte at a time.
- Frame format: header byte, then the data bytes, then an XOR checksum byte.
- Sits between the SDRAM read FIFO (standard-mode, 1-cycle read latency) and uart_tx. It is the host-facing counterpart of the command decoder.

Parameters:
- BYTE_NUM, 4, data bytes per frame (2..255). Matches the write-command payload length.
- HEAD, 8'hA5, frame header byte.
- TIMEOUT, 1023, max consecutive cycles in FETCH with rfifo_empty=1 before the frame is aborted.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rd_done  input  1  1-cycle pulse: SDRAM read burst complete, BYTE_NUM bytes available in the read FIFO.
- rfifo_empty  input  1  read FIFO empty flag.
- rfifo_rd_data  input  8  read FIFO data, valid the cycle after rfifo_rd_en.
- rfifo_rd_en  output  1  read FIFO pop, 1-cycle pulse, registered.
- flag_tx_end  input  1  1-cycle pulse from uart_tx: the current byte's stop bit has completed.
- tx_trig  output  1  1-cycle start pulse to uart_tx, registered.
- tx_data  output  8  byte to transmit. Valid on the tx_trig cycle and held until the next tx_trig.
- busy  output  1  frame in progress.
- tx_done  output  1  1-cycle pulse: frame fully sent, checksum included.
- err  output  1  1-cycle pulse: frame aborted on FIFO-empty timeout.

Behaviour:
- Reset (async, any state): all outputs 0, tx_data 8'h00, FSM to IDLE, byte counter, checksum and timeout counter cleared. A partial frame is dropped and never resumed.
- States: IDLE, HEAD, WAIT_H, FETCH, LATCH, SEND, WAIT_D, CHK, WAIT_C.
- IDLE:
  - rd_done=1 -> HEAD. busy rises the cycle after rd_done is sampled.
  - rd_done in any other state is ignored; no queuing.
- HEAD: tx_trig=1, tx_data=HEAD for one cycle -> WAIT_H. This tx_trig occurs 1 cycle after rd_done.
- WAIT_H: flag_tx_end -> FETCH.
- FETCH:
  - rfifo_empty=0: rfifo_rd_en=1 for one cycle -> LATCH.
  - rfifo_empty=1: stay in FETCH and increment the timeout counter.
  - Counter reaching TIMEOUT: err=1, busy=0, -> IDLE. No checksum is sent.
  - Timeout counter clears on every exit from FETCH.
- LATCH: sample rfifo_rd_data into tx_data, update chk <= chk ^ rfifo_rd_data -> SEND.
- SEND: tx_trig=1 -> WAIT_D. tx_trig lands exactly 2 cycles after rfifo_rd_en.
- WAIT_D: on flag_tx_end:
  - byte counter == BYTE_NUM-1 -> CHK.
  - otherwise increment the counter -> FETCH.
- CHK: tx_data=chk, tx_trig=1 -> WAIT_C.
- WAIT_C: on flag_tx_end -> IDLE. tx_done=1 and busy=0 in the following cycle.
- Checksum: 8-bit XOR of data bytes only. HEAD is excluded. Cleared on entry to HEAD.
- flag_tx_end outside the WAIT_* states is ignored.
- flag_tx_end on the same cycle as tx_trig is ignored (stale end from the previous byte).
- Exactly BYTE_NUM rfifo_rd_en pulses per completed frame. Never more than one pop per byte, never a pop while rfifo_empty=1.
- Byte counter is 8 bits and wraps only via explicit clear on HEAD.
- Back-to-back frames: rd_done may arrive on the same cycle tx_done is asserted. It is accepted, because the FSM is already in IDLE.

Test Plan:
- FIFO preloaded 11,22,33,44; rd_done pulse; uart model returns flag_tx_end 10 cycles after each tx_trig.
  -> tx_data sequence A5,11,22,33,44,44 (chk=0x44); 4 rfifo_rd_en pulses; tx_done once; busy low after.
- FIFO empty at the second fetch for 50 cycles, then byte 0x22 pushed.
  -> stall in FETCH with no tx_trig and no rd_en; resumes; frame and checksum correct.
- FIFO held empty after the header, TIMEOUT=15.
  -> err pulse 15 cycles after entering FETCH; busy=0; no checksum byte; next rd_done starts a fresh frame with chk reset.
- rd_done pulses during WAIT_D.
  -> ignored; exactly one frame of 6 bytes.
- rst_n low mid-byte-2, then released, then new rd_done with FIFO 01,02,03,04.
  -> all outputs 0 during reset; new frame A5,01,02,03,04,04.
- Two frames back to back, with rd_done coincident with tx_done.
  -> second header's tx_trig 1 cycle later; 12 bytes total with correct checksums.
